// File: rtl/uart_tx_8n1.sv
// ----------------------------------------------------------------------------
// uart_tx_8n1
//
// Byte-wide 8N1 UART transmitter. One byte is accepted per valid/ready
// handshake and shifted out as 1 start bit (low), 8 data bits LSB first and
// 1 stop bit (high). Bit timing comes from a clock-enable style baud counter
// running on the system clock, so no derived clock is generated.
//
// Parameters
//   FSYS_CLK  system clock frequency in Hz
//   BAND_SET  line baud rate; DIV = FSYS_CLK / BAND_SET cycles per bit (>= 2)
//
// Ports
//   clk_50mhz  system clock, all logic on its rising edge
//   rst_n      asynchronous active-low reset
//   tx_data    byte to send, sampled only on the acceptance edge
//   tx_valid   request to send tx_data
//   tx_ready   registered, high while idle and able to accept a byte
//   tx         registered serial line, idles high
//   tx_done    registered one-cycle pulse when a stop bit completes
// ----------------------------------------------------------------------------
module uart_tx_8n1 #(
   parameter int FSYS_CLK = 50_000_000,
   parameter int BAND_SET = 115200
) (
   input  logic       clk_50mhz,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_done
);

   localparam int          DIV      = FSYS_CLK / BAND_SET;
   localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t      state_q;
   logic [15:0] baudCnt_q;
   logic [15:0] baudCnt_d;
   logic [2:0]  bitIdx_q;
   logic [7:0]  shift_q;
   logic        tx_q;
   logic        ready_q;
   logic        done_q;
   logic        bitEnd;

   // The last cycle of every bit is where the counter reaches DIV-1; the
   // counter then wraps so the next bit starts at phase 0 again.
   assign bitEnd    = (baudCnt_q == DIV_LAST);
   assign baudCnt_d = bitEnd ? 16'd0 : baudCnt_q + 16'd1;

   // Single registered FSM. The line value for the next bit is loaded on the
   // same edge that moves into that bit, which keeps tx glitch-free and
   // exactly one cycle behind the acceptance edge. In IDLE the counter is
   // held at zero so each frame is phase-aligned to its own acceptance.
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         baudCnt_q <= 16'd0;
         bitIdx_q  <= 3'd0;
         shift_q   <= 8'h00;
         tx_q      <= 1'b1;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               baudCnt_q <= 16'd0;
               if (tx_valid && ready_q) begin
                  shift_q  <= tx_data;
                  bitIdx_q <= 3'd0;
                  state_q  <= START;
                  tx_q     <= 1'b0;
                  ready_q  <= 1'b0;
               end
            end
            START: begin
               baudCnt_q <= baudCnt_d;
               if (bitEnd) begin
                  state_q <= DATA;
                  tx_q    <= shift_q[0];
               end
            end
            DATA: begin
               baudCnt_q <= baudCnt_d;
               if (bitEnd) begin
                  shift_q  <= {1'b0, shift_q[7:1]};
                  bitIdx_q <= bitIdx_q + 3'd1;
                  if (bitIdx_q == 3'd7) begin
                     state_q <= STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     tx_q <= shift_q[1];
                  end
               end
            end
            STOP: begin
               baudCnt_q <= baudCnt_d;
               if (bitEnd) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign tx       = tx_q;
   assign tx_ready = ready_q;
   assign tx_done  = done_q;

endmodule
